// File: rtl/cond_logic_unit_if.sv
// Decoder/ALU-facing signal bundle for cond_logic_unit.
// master drives the instruction side; slave is the conditional-execution stage.
interface cond_logic_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic             en;
  logic             valid_i;
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             PCS;
  logic             RegW;
  logic             MemW;
  logic             PCSrc;
  logic             RegWrite;
  logic             MemWrite;
  logic             CondEx;
  logic             squashed;
  logic [3:0]       Flags;
  logic             shadow_active;
  logic [CNT_W-1:0] exec_count;
  logic [CNT_W-1:0] squash_count;

  modport master (
    output en, valid_i, Cond, ALUFlags, FlagW, PCS, RegW, MemW,
    input  PCSrc, RegWrite, MemWrite, CondEx, squashed, Flags,
           shadow_active, exec_count, squash_count
  );

  modport slave (
    input  en, valid_i, Cond, ALUFlags, FlagW, PCS, RegW, MemW,
    output PCSrc, RegWrite, MemWrite, CondEx, squashed, Flags,
           shadow_active, exec_count, squash_count
  );
endinterface

// File: rtl/cond_logic_unit.sv
// Conditional-execution stage: NZCV flag register, write-enable/PC-select gating,
// branch-shadow squashing and saturating exec/squash counters.
module cond_logic_unit #(
  parameter int unsigned BRANCH_SHADOW = 2,
  parameter int unsigned CNT_W         = 16
) (
  input logic              clk,
  input logic              reset,
  cond_logic_unit_if.slave bus
);
  localparam int unsigned SW = (BRANCH_SHADOW > 0) ? $clog2(BRANCH_SHADOW + 1) : 1;

  logic [3:0]       flags;
  logic [SW-1:0]    shadow;
  logic [CNT_W-1:0] exec_cnt;
  logic [CNT_W-1:0] squash_cnt;
  logic             n, z, c, v;
  logic             cond_true;
  logic             shadow_nz;
  logic             live;
  logic             condex;
  logic             squash;
  logic             pcsrc;

  assign {n, z, c, v} = flags;

  always_comb begin
    cond_true = 1'b0;
    case (bus.Cond)
      4'h0:    cond_true = z;
      4'h1:    cond_true = !z;
      4'h2:    cond_true = c;
      4'h3:    cond_true = !c;
      4'h4:    cond_true = n;
      4'h5:    cond_true = !n;
      4'h6:    cond_true = v;
      4'h7:    cond_true = !v;
      4'h8:    cond_true = c & !z;
      4'h9:    cond_true = !c | z;
      4'hA:    cond_true = (n == v);
      4'hB:    cond_true = (n != v);
      4'hC:    cond_true = !z & (n == v);
      4'hD:    cond_true = z | (n != v);
      4'hE:    cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  assign shadow_nz = (shadow != '0);
  assign live      = bus.en & bus.valid_i;
  assign condex    = live & cond_true & !shadow_nz;
  assign squash    = live & shadow_nz;
  assign pcsrc     = bus.PCS & condex;

  // A zero-length shadow collapses the counter to a constant so nothing is ever squashed.
  generate
    if (BRANCH_SHADOW == 0) begin : g_no_shadow
      assign shadow = '0;
    end else begin : g_shadow
      localparam logic [SW-1:0] SHADOW_LOAD = SW'(BRANCH_SHADOW);
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          shadow <= '0;
        end else if (pcsrc) begin
          shadow <= SHADOW_LOAD;
        end else if (squash) begin
          shadow <= shadow - 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags <= '0;
    end else if (condex) begin
      if (bus.FlagW[1]) flags[3:2] <= bus.ALUFlags[3:2];
      if (bus.FlagW[0]) flags[1:0] <= bus.ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exec_cnt   <= '0;
      squash_cnt <= '0;
    end else begin
      if (condex && (exec_cnt != '1))   exec_cnt   <= exec_cnt + 1'b1;
      if (squash && (squash_cnt != '1)) squash_cnt <= squash_cnt + 1'b1;
    end
  end

  assign bus.CondEx        = condex;
  assign bus.squashed      = squash;
  assign bus.PCSrc         = pcsrc;
  assign bus.RegWrite      = bus.RegW & condex;
  assign bus.MemWrite      = bus.MemW & condex;
  assign bus.Flags         = flags;
  assign bus.shadow_active = shadow_nz;
  assign bus.exec_count    = exec_cnt;
  assign bus.squash_count  = squash_cnt;
endmodule
